pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen_pkg.sv | 20 ++
 rtl/pwm_gen_if.sv | 26 ++
 rtl/pwm_gen_deadtime.sv | 45 ++++
 rtl/pwm_gen.sv | 101 ++++++++++
 tb/tb_pwm_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared types and defaults for the PWM generator: FSM state encoding,
// default widths and the "outputs live" state helper.
package pwm_gen_pkg;

    localparam int PWM_WIDTH    = 8;
    localparam int PWM_DT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } pwm_state_e;

    // RUN and DRAIN both drive the comparator; IDLE/ARM hold outputs low.
    function automatic logic is_active(input pwm_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Counter/duty/PWM signal bundle between the counter stage (master) and pwm_gen (slave).
interface pwm_gen_if import pwm_gen_pkg::*; #(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int DT_WIDTH = PWM_DT_WIDTH
);
    logic [WIDTH-1:0]    count;
    logic                overflow;
    logic                en;
    logic                duty_valid;
    logic                duty_ready;
    logic [WIDTH-1:0]    duty_data;
    logic [DT_WIDTH-1:0] dt;
    logic                pwm_out;
    logic                pwm_out_n;
    logic                period_done;

    modport master (
        output count, overflow, en, duty_valid, duty_data, dt,
        input  duty_ready, pwm_out, pwm_out_n, period_done
    );

    modport slave (
        input  count, overflow, en, duty_valid, duty_data, dt,
        output duty_ready, pwm_out, pwm_out_n, period_done
    );
endinterface

// File: rtl/pwm_gen_deadtime.sv
// Dead-time inserter: each output rises only once raw has held its level for
// more than dt cycles, and falls on the cycle raw changes.
module pwm_deadtime import pwm_gen_pkg::*; #(
    parameter int DT_WIDTH = PWM_DT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_raw,
    input  logic                i_run,
    input  logic [DT_WIDTH-1:0] i_dt,
    output logic                o_hi,
    output logic                o_lo
);
    localparam int CW = DT_WIDTH + 1;

    logic          r_prev;
    logic [CW-1:0] r_len;
    logic [CW-1:0] w_len;
    logic          w_settled;

    // Run length including this cycle; one extra bit so it can exceed dt max.
    always_comb begin
        w_len = r_len;
        if (i_raw != r_prev)
            w_len = CW'(1);
        else if (r_len != {CW{1'b1}})
            w_len = r_len + CW'(1);
    end

    assign w_settled = w_len > {1'b0, i_dt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_len  <= '0;
            o_hi   <= 1'b0;
            o_lo   <= 1'b0;
        end else begin
            r_prev <= i_raw;
            r_len  <= w_len;
            o_hi   <= i_raw && w_settled;
            o_lo   <= i_run && !i_raw && w_settled;
        end
    end
endmodule

// File: rtl/pwm_gen.sv
// PWM generator: compares the upstream count against a per-period duty.
// Dead-time insertion is built only when PWM_GEN_DEADTIME_EN is defined.
module pwm_gen import pwm_gen_pkg::*; #(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int DT_WIDTH = PWM_DT_WIDTH
) (
    input logic     clk,
    input logic     rst_n,
    pwm_gen_if.slave bus
);
    pwm_state_e       r_state;
    logic             r_pdone;
    logic [WIDTH-1:0] r_duty_active;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_pend;
    logic             w_run;
    logic             w_raw;

    assign w_run = is_active(r_state);
    assign w_raw = w_run && (bus.count < r_duty_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pdone <= 1'b0;
        end else begin
            r_pdone <= bus.overflow && w_run;
            case (r_state)
                ST_IDLE:  if (bus.en) r_state <= ST_ARM;
                ST_ARM:   if (!bus.en) r_state <= ST_IDLE;
                          else if (bus.overflow) r_state <= ST_RUN;
                ST_RUN:   if (!bus.en) r_state <= ST_DRAIN;
                // Re-enable wins over the wrap so a late en keeps the output gapless.
                ST_DRAIN: if (bus.en) r_state <= ST_RUN;
                          else if (bus.overflow) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Copy uses the flag as it stood before this edge, so a write landing on
    // the overflow cycle waits a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_active <= '0;
            r_pend_val    <= '0;
            r_pend        <= 1'b0;
        end else if (bus.overflow && r_pend) begin
            r_duty_active <= r_pend_val;
            r_pend        <= 1'b0;
        end else if (bus.duty_valid && !r_pend) begin
            r_pend_val <= bus.duty_data;
            r_pend     <= 1'b1;
        end
    end

    assign bus.duty_ready  = !r_pend;
    assign bus.period_done = r_pdone;

`ifdef PWM_GEN_DEADTIME_EN
    logic [DT_WIDTH-1:0] r_dt;
    logic                w_hi;
    logic                w_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dt <= '0;
        else if (bus.overflow)
            r_dt <= bus.dt;
    end

    pwm_deadtime #(.DT_WIDTH(DT_WIDTH)) u_deadtime (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (w_raw),
        .i_run (w_run),
        .i_dt  (r_dt),
        .o_hi  (w_hi),
        .o_lo  (w_lo)
    );

    assign bus.pwm_out   = w_hi;
    assign bus.pwm_out_n = w_lo;
`else
    logic r_raw;
    logic r_outn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw  <= 1'b0;
            r_outn <= 1'b0;
        end else begin
            r_raw  <= w_raw;
            r_outn <= w_run && !w_raw;
        end
    end

    assign bus.pwm_out   = r_raw;
    assign bus.pwm_out_n = r_outn;
`endif
endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: a cycle model predicts outputs per driven count;
// period totals are checked against hand-derived figures.
module tb_pwm_gen;
    import pwm_gen_pkg::*;

    localparam int W  = 8;
    localparam int DW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_gen_if #(.WIDTH(W), .DT_WIDTH(DW)) bus();

    pwm_gen #(.WIDTH(W), .DT_WIDTH(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic o;
        logic on;
        logic pd;
        logic rdy;
    } obs_t;

    obs_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // reference model state
    pwm_state_e m_st;
    logic [7:0] m_act, m_pval;
    logic       m_pend;
    logic [3:0] m_dt;
    logic       m_prev;
    int         m_len;

    int cnt;
    int h_o, h_on, h_both, h_pd, stall;

    task automatic model_reset();
        m_st   = ST_IDLE;
        m_act  = '0;
        m_pval = '0;
        m_pend = 1'b0;
        m_dt   = '0;
        m_prev = 1'b0;
        m_len  = 0;
    endtask

    task automatic cyc();
        logic [7:0] c8;
        logic run, raw, ovf, acc, pnd_n, eo, eon;
        int   len;
        obs_t e, g;
        c8  = cnt[7:0];
        ovf = (cnt == 255);
        bus.count    = c8;
        bus.overflow = ovf;
        run = (m_st == ST_RUN) || (m_st == ST_DRAIN);
        raw = run && (c8 < m_act);
        len = (raw == m_prev) ? ((m_len < 31) ? m_len + 1 : m_len) : 1;
`ifdef PWM_GEN_DEADTIME_EN
        eo  = raw && (len > int'(m_dt));
        eon = run && !raw && (len > int'(m_dt));
`else
        eo  = raw;
        eon = run && !raw;
`endif
        acc = rst_n && bus.duty_valid && !m_pend;
        if (bus.duty_valid && !acc) stall++;
        pnd_n = (ovf && m_pend) ? 1'b0 : (acc ? 1'b1 : m_pend);
        if (!rst_n) begin
            e.o = 1'b0; e.on = 1'b0; e.pd = 1'b0; e.rdy = 1'b1;
        end else begin
            e.o = eo; e.on = eon; e.pd = ovf && run; e.rdy = !pnd_n;
        end
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        g.o   = bus.pwm_out;
        g.on  = bus.pwm_out_n;
        g.pd  = bus.period_done;
        g.rdy = bus.duty_ready;
        e = sb_q.pop_front();
        chk($sformatf("cyc_cnt%0d{o,on,pd,rdy}", cnt), 32'(g), 32'(e));
        h_o    += int'(g.o);
        h_on   += int'(g.on);
        h_both += int'(!g.o && !g.on);
        h_pd   += int'(g.pd);
        if (acc) bus.duty_valid = 1'b0;

        if (!rst_n) begin
            model_reset();
        end else begin
            m_prev = raw;
            m_len  = len;
            if (ovf) m_dt = bus.dt;
            if (ovf && m_pend) begin
                m_act  = m_pval;
                m_pend = 1'b0;
            end else if (acc) begin
                m_pval = bus.duty_data;
                m_pend = 1'b1;
            end
            case (m_st)
                ST_IDLE:  if (bus.en) m_st = ST_ARM;
                ST_ARM:   if (!bus.en) m_st = ST_IDLE; else if (ovf) m_st = ST_RUN;
                ST_RUN:   if (!bus.en) m_st = ST_DRAIN;
                default:  if (bus.en) m_st = ST_RUN; else if (ovf) m_st = ST_IDLE;
            endcase
        end
        cnt = (cnt + 1) % 256;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 300 && cnt != target; k++) cyc();
    endtask

    // One full period from count 0 with optional en/duty events.
    task automatic measure(input int off_at, input int on_at, input int wr_at, input int wr_data);
        h_o = 0; h_on = 0; h_both = 0; h_pd = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == off_at) bus.en = 1'b0;
            if (i == on_at)  bus.en = 1'b1;
            if (i == wr_at) begin
                bus.duty_valid = 1'b1;
                bus.duty_data  = 8'(wr_data);
            end
            cyc();
        end
    endtask

    task automatic chk_period(input string tag, input int eo, input int eon, input int epd);
        chk({tag, "_hi"},   32'(h_o),  32'(eo));
        chk({tag, "_hin"},  32'(h_on), 32'(eon));
        chk({tag, "_pdone"}, 32'(h_pd), 32'(epd));
    endtask

    initial begin
        bus.count = '0; bus.overflow = 1'b0; bus.en = 1'b0;
        bus.duty_valid = 1'b0; bus.duty_data = '0; bus.dt = '0;
        cnt = 0; stall = 0;
        model_reset();

        repeat (3) cyc();
        chk("rst_pwm_out",   32'(bus.pwm_out),     32'd0);
        chk("rst_pwm_out_n", 32'(bus.pwm_out_n),   32'd0);
        chk("rst_pdone",     32'(bus.period_done), 32'd0);
        chk("rst_ready",     32'(bus.duty_ready),  32'd1);
        rst_n = 1'b1;

        // duty 64 from IDLE
        bus.en = 1'b1;
        bus.duty_valid = 1'b1; bus.duty_data = 8'd64;
        run_to(0);
        measure(-1, -1, -1, 0);
        chk_period("duty64", 64, 192, 1);

        // write 128 at count 10, second write stalls until after overflow
        run_to(10);
        bus.duty_valid = 1'b1; bus.duty_data = 8'd128;
        cyc();
        chk("ready_after_wr", 32'(bus.duty_ready), 32'd0);
        bus.duty_valid = 1'b1; bus.duty_data = 8'd32;
        stall = 0;
        run_to(0);
        chk("stall_cycles", 32'(stall), 32'd245);
        chk("ready_after_ovf", 32'(bus.duty_ready), 32'd1);
        measure(-1, -1, -1, 0);
        chk_period("duty128", 128, 128, 1);

        // drain and re-enable in the same period, then drain to IDLE
        measure(100, 200, -1, 0);
        chk_period("drain_reen", 32, 224, 1);
        measure(100, -1, -1, 0);
        chk_period("drain_end", 32, 224, 1);
        measure(-1, -1, -1, 0);
        chk_period("idle", 0, 0, 0);

        // duty 0, then a write on the overflow cycle applies one period later
        bus.en = 1'b1;
        bus.duty_valid = 1'b1; bus.duty_data = 8'd0;
        measure(-1, -1, -1, 0);
        chk_period("arm", 0, 0, 0);
        measure(-1, -1, 255, 255);
        chk_period("duty0_a", 0, 256, 1);
        measure(-1, -1, -1, 0);
        chk_period("duty0_b", 0, 256, 1);
        measure(-1, -1, -1, 0);
        chk_period("duty255", 255, 1, 1);

        // async reset mid-period with a duty write pending
        run_to(5);
        bus.duty_valid = 1'b1; bus.duty_data = 8'd100;
        run_to(30);
        cyc();
        chk("pre_rst_ready", 32'(bus.duty_ready), 32'd0);
        chk("pre_rst_out",   32'(bus.pwm_out),    32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out",   32'(bus.pwm_out),     32'd0);
        chk("async_rst_out_n", 32'(bus.pwm_out_n),   32'd0);
        chk("async_rst_pdone", 32'(bus.period_done), 32'd0);
        chk("async_rst_ready", 32'(bus.duty_ready),  32'd1);
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        run_to(0);
        measure(-1, -1, -1, 0);
        chk_period("post_rst_lost", 0, 256, 1);

`ifdef PWM_GEN_DEADTIME_EN
        bus.dt = 4'd4;
        bus.duty_valid = 1'b1; bus.duty_data = 8'd64;
        measure(-1, -1, -1, 0);
        measure(-1, -1, -1, 0);
        chk_period("dt4_duty64", 60, 188, 1);
        chk("dt4_both_low", 32'(h_both), 32'd8);
        bus.dt = 4'd15;
        bus.duty_valid = 1'b1; bus.duty_data = 8'd10;
        measure(-1, -1, -1, 0);
        measure(-1, -1, -1, 0);
        chk_period("dt15_duty10", 0, 231, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
